// File: rtl/legup_mult_arbiter.sv
// Round-robin arbiter that time-shares one pipelined multiplier among
// NUM_REQ requesters and routes each product back tagged with its owner.
module legup_mult_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTHA   = 32,
    parameter int unsigned WIDTHB   = 32,
    parameter int unsigned WIDTHP   = 64,
    parameter int unsigned PIPELINE = 3
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTHA-1:0]    req_dataa,
    input  logic [NUM_REQ*WIDTHB-1:0]    req_datab,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic [WIDTHP-1:0]            res_data,
    output logic [WIDTHA-1:0]            mult_dataa,
    output logic [WIDTHB-1:0]            mult_datab,
    output logic                         mult_clken,
    output logic                         mult_aclr,
    input  logic [WIDTHP-1:0]            mult_result,
    output logic                         busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned TAG_W = PIPELINE * ID_W;

    // Tag pipeline mirrors the multiplier stages; bit/entry PIPELINE-1 is the output stage.
    logic [PIPELINE-1:0]           tag_valid_q, tag_valid_d;
    logic [PIPELINE-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;

    logic            stall;
    logic            issue;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [SUM_W-1:0] search_sum;
    logic [ID_W-1:0] search_idx;

    // Backpressure only when a valid product sits unaccepted at the output stage.
    always_comb begin
        stall      = tag_valid_q[PIPELINE-1] & ~res_ready;
        issue      = resetn & ~stall & (|req_valid);
        mult_clken = ~stall | ~resetn;
        mult_aclr  = ~resetn;
    end

    // Round-robin search upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
    always_comb begin
        grant_id    = rr_ptr_q;
        grant_found = 1'b0;
        search_sum  = '0;
        search_idx  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            search_sum = {1'b0, rr_ptr_q} + SUM_W'(off);
            if (search_sum >= SUM_W'(NUM_REQ)) begin
                search_sum = search_sum - SUM_W'(NUM_REQ);
            end
            search_idx = ID_W'(search_sum);
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_id    = search_idx;
            end
        end
    end

    // Grant strobe and operand mux; operands are forced to zero when nothing issues.
    always_comb begin
        req_ready  = '0;
        mult_dataa = '0;
        mult_datab = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            mult_dataa          = req_dataa[grant_id*WIDTHA +: WIDTHA];
            mult_datab          = req_datab[grant_id*WIDTHB +: WIDTHB];
        end
    end

    // Next-state: tags advance with the multiplier enable, pointer moves past the winner.
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_id_d    = tag_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (mult_clken) begin
            tag_valid_d = (tag_valid_q << 1) | PIPELINE'(issue);
            tag_id_d    = (tag_id_q << ID_W) | TAG_W'(grant_id);
        end
        if (issue) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Result side is a straight view of the output stage and the multiplier product.
    always_comb begin
        res_valid = tag_valid_q[PIPELINE-1];
        res_id    = tag_id_q[PIPELINE-1];
        res_data  = mult_result;
        busy      = |tag_valid_q;
    end

endmodule

// File: tb/tb_legup_mult_arbiter.sv
// Bench for legup_mult_arbiter: directed vector table, hand sequences for
// backpressure and mid-flight reset, then random traffic against a queue model.
module tb_legup_mult_arbiter;

    localparam int N   = 4;
    localparam int P   = 3;
    localparam int WA  = 32;
    localparam int WB  = 32;
    localparam int WP  = 64;
    localparam int IDW = 2;

    logic              clock = 1'b0;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WA-1:0]   req_dataa;
    logic [N*WB-1:0]   req_datab;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [WP-1:0]     res_data;
    logic [WA-1:0]     mult_dataa;
    logic [WB-1:0]     mult_datab;
    logic              mult_clken;
    logic              mult_aclr;
    logic [WP-1:0]     mult_result;
    logic              busy;

    legup_mult_arbiter #(
        .NUM_REQ(N), .WIDTHA(WA), .WIDTHB(WB), .WIDTHP(WP), .PIPELINE(P)
    ) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dataa(req_dataa), .req_datab(req_datab),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab),
        .mult_clken(mult_clken), .mult_aclr(mult_aclr),
        .mult_result(mult_result), .busy(busy)
    );

    always #5 clock = ~clock;

    // Shared unsigned multiplier with P enabled stages of latency.
    logic [WP-1:0] mstage [P];
    always @(posedge clock) begin
        if (mult_aclr) begin
            for (int i = 0; i < P; i++) mstage[i] <= '0;
        end else if (mult_clken) begin
            mstage[0] <= {32'b0, mult_dataa} * {32'b0, mult_datab};
            for (int i = 1; i < P; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mult_result = mstage[P-1];

    int checks;
    int failures;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: in-order queue of in-flight products, each aged in enabled clocks.
    typedef struct {
        int          id;
        logic [63:0] prod;
        int          age;
    } item_t;

    item_t       q[$];
    int          m_rr;
    logic        m_issue;
    logic        m_stall;
    logic        m_xfer;
    int          m_grant;
    logic [63:0] m_prod;
    int          dut_issues;
    int          dut_xfers;

    task automatic model_check();
        logic         ev;
        logic         found;
        int           idx;
        logic [N-1:0] er;
        logic [WA-1:0] ea;
        logic [WB-1:0] eb;
        ev      = (q.size() > 0) && (q[0].age == P);
        m_stall = ev && !res_ready;
        m_xfer  = ev && res_ready && resetn;
        m_issue = resetn && !m_stall && (req_valid != '0);
        m_grant = 0;
        found   = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = (m_rr + off) % N;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                m_grant = idx;
            end
        end
        er = '0;
        ea = '0;
        eb = '0;
        if (m_issue) begin
            er[m_grant] = 1'b1;
            ea = req_dataa[m_grant*WA +: WA];
            eb = req_datab[m_grant*WB +: WB];
        end
        m_prod = {32'b0, ea} * {32'b0, eb};
        cmp("m_req_ready", req_ready, er);
        cmp("m_clken", mult_clken, !m_stall || !resetn);
        cmp("m_aclr", mult_aclr, !resetn);
        cmp("m_res_valid", res_valid, ev);
        cmp("m_busy", busy, q.size() > 0);
        cmp("m_dataa", mult_dataa, ea);
        cmp("m_datab", mult_datab, eb);
        if (ev) begin
            cmp("m_res_id", res_id, q[0].id);
            cmp("m_res_data", res_data, q[0].prod);
        end
        if (resetn && req_ready != '0) dut_issues++;
        if (resetn && res_valid && res_ready) dut_xfers++;
    endtask

    task automatic model_update();
        item_t it;
        if (!resetn) begin
            q.delete();
            m_rr = 0;
        end else begin
            if (m_xfer) void'(q.pop_front());
            if (!m_stall) begin
                foreach (q[i]) q[i].age++;
            end
            if (m_issue) begin
                it.id   = m_grant;
                it.prod = m_prod;
                it.age  = 1;
                q.push_back(it);
                m_rr = (m_grant + 1) % N;
            end
        end
    endtask

    // Drive one cycle's inputs away from the active edge and run the model checks.
    task automatic cycle_begin(input logic rn, input logic [N-1:0] rv,
                               input logic [N*WA-1:0] da, input logic [N*WB-1:0] db,
                               input logic rr);
        @(negedge clock);
        resetn    = rn;
        req_valid = rv;
        req_dataa = da;
        req_datab = db;
        res_ready = rr;
        #1;
        model_check();
    endtask

    task automatic cycle_end();
        @(posedge clock);
        model_update();
    endtask

    typedef struct {
        logic           rstn;
        logic [N-1:0]   rv;
        logic           rdy;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [N-1:0]   e_ready;
        logic           e_valid;
        logic [IDW-1:0] e_id;
        logic [63:0]    e_data;
        logic           e_busy;
    } vec_t;

    function automatic vec_t mk(input logic rstn, input logic [N-1:0] rv, input logic rdy,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [N-1:0] e_ready, input logic e_valid,
                                input logic [IDW-1:0] e_id, input logic [63:0] e_data,
                                input logic e_busy);
        vec_t v;
        v.rstn = rstn; v.rv = rv; v.rdy = rdy; v.a = a; v.b = b;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_id = e_id;
        v.e_data = e_data; v.e_busy = e_busy;
        return v;
    endfunction

    vec_t            tbl [24];
    logic [N*WA-1:0] rda;
    logic [N*WB-1:0] rdb;
    logic [63:0]     held;
    int              x0;

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_dataa = '0;
        req_datab = '0;
        res_ready = 1'b0;
        checks    = 0;
        failures  = 0;
        m_rr      = 0;
        dut_issues = 0;
        dut_xfers  = 0;

        // Single request, wrap, reset, then full rotation.
        tbl[0]  = mk(1, 4'b0010, 1, 7, 6, 4'b0010, 0, 0, 0, 0);
        tbl[1]  = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 1);
        tbl[2]  = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 1);
        tbl[3]  = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 1, 42, 1);
        tbl[4]  = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        tbl[5]  = mk(1, 4'b0100, 1, 3, 5, 4'b0100, 0, 0, 0, 0);
        tbl[6]  = mk(1, 4'b1001, 1, 4, 5, 4'b1000, 0, 0, 0, 1);
        tbl[7]  = mk(1, 4'b1001, 1, 6, 5, 4'b0001, 0, 0, 0, 1);
        tbl[8]  = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 2, 15, 1);
        tbl[9]  = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 3, 20, 1);
        tbl[10] = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 30, 1);
        tbl[11] = mk(0, 4'b1111, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
        tbl[12] = mk(1, 4'b1111, 1, 13, 3, 4'b0001, 0, 0, 0, 0);
        tbl[13] = mk(1, 4'b1111, 1, 14, 3, 4'b0010, 0, 0, 0, 1);
        tbl[14] = mk(1, 4'b1111, 1, 15, 3, 4'b0100, 0, 0, 0, 1);
        tbl[15] = mk(1, 4'b1111, 1, 16, 3, 4'b1000, 1, 0, 39, 1);
        tbl[16] = mk(1, 4'b1111, 1, 17, 3, 4'b0001, 1, 1, 42, 1);
        tbl[17] = mk(1, 4'b1111, 1, 18, 3, 4'b0010, 1, 2, 45, 1);
        tbl[18] = mk(1, 4'b1111, 1, 19, 3, 4'b0100, 1, 3, 48, 1);
        tbl[19] = mk(1, 4'b1111, 1, 20, 3, 4'b1000, 1, 0, 51, 1);
        tbl[20] = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 1, 54, 1);
        tbl[21] = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 2, 57, 1);
        tbl[22] = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 3, 60, 1);
        tbl[23] = mk(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 0);

        // Reset state.
        cycle_begin(0, 4'b1111, '1, '1, 1);
        cmp("rst_req_ready", req_ready, 0);
        cmp("rst_clken", mult_clken, 1);
        cmp("rst_aclr", mult_aclr, 1);
        cmp("rst_res_valid", res_valid, 0);
        cmp("rst_busy", busy, 0);
        cycle_end();

        for (int i = 0; i < 24; i++) begin
            cycle_begin(tbl[i].rstn, tbl[i].rv, {N{tbl[i].a}}, {N{tbl[i].b}}, tbl[i].rdy);
            cmp($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_ready);
            cmp($sformatf("tbl%0d_res_valid", i), res_valid, tbl[i].e_valid);
            cmp($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_valid) begin
                cmp($sformatf("tbl%0d_res_id", i), res_id, tbl[i].e_id);
                cmp($sformatf("tbl%0d_res_data", i), res_data, tbl[i].e_data);
            end
            cycle_end();
        end

        // Backpressure: three products from requester 2, then hold res_ready low.
        for (int k = 0; k < 3; k++) begin
            cycle_begin(1, 4'b0100, {N{32'(100 + k)}}, {N{32'd3}}, 1);
            cycle_end();
        end
        held = 64'd300;
        for (int k = 0; k < 5; k++) begin
            cycle_begin(1, 4'b0100, {N{32'(200 + k)}}, {N{32'd3}}, 0);
            cmp($sformatf("bp%0d_clken", k), mult_clken, 0);
            cmp($sformatf("bp%0d_req_ready", k), req_ready, 0);
            cmp($sformatf("bp%0d_res_valid", k), res_valid, 1);
            cmp($sformatf("bp%0d_res_id", k), res_id, 2);
            cmp($sformatf("bp%0d_res_data", k), res_data, held);
            cycle_end();
        end
        x0 = dut_xfers;
        for (int k = 0; k < 6; k++) begin
            cycle_begin(1, 4'b0000, '0, '0, 1);
            cycle_end();
        end
        cmp("bp_resume_xfers", 64'(dut_xfers - x0), 3);

        // Reset with three products in flight.
        for (int k = 0; k < 3; k++) begin
            cycle_begin(1, 4'b1111, {N{32'(k + 1)}}, {N{32'd7}}, 1);
            cycle_end();
        end
        cycle_begin(0, 4'b1111, {N{32'd9}}, {N{32'd9}}, 1);
        cmp("mid_rst_req_ready", req_ready, 0);
        cmp("mid_rst_clken", mult_clken, 1);
        cycle_end();
        cycle_begin(1, 4'b1111, {N{32'd5}}, {N{32'd5}}, 1);
        cmp("post_rst_res_valid", res_valid, 0);
        cmp("post_rst_busy", busy, 0);
        cmp("post_rst_grant", req_ready, 4'b0001);
        cycle_end();
        for (int k = 0; k < 5; k++) begin
            cycle_begin(1, 4'b0000, '0, '0, 1);
            cycle_end();
        end

        // Random traffic with random downstream backpressure.
        dut_issues = 0;
        dut_xfers  = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                rda[i*WA +: WA] = $urandom();
                rdb[i*WB +: WB] = $urandom();
            end
            cycle_begin(1, N'($urandom_range(0, 15)), rda, rdb, $urandom_range(0, 9) < 7);
            cycle_end();
        end
        cmp("rand_issue_balance", 64'(dut_issues), 64'(dut_xfers + q.size()));
        for (int k = 0; k < P + 3; k++) begin
            cycle_begin(1, 4'b0000, '0, '0, 1);
            cycle_end();
        end
        cmp("drain_issue_xfer", 64'(dut_issues), 64'(dut_xfers));
        cmp("drain_empty", 64'(q.size()), 0);
        cmp("drain_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
